// File: rtl/counter_pkg.sv
// counter_pkg: shared definitions for the counter DUT, its reference model
// and the self-checking monitor.
//   checker_state_e : monitor state encoding (IDLE, CHECK, FAIL)
//   COUNTER_WIDTH   : default counter width for top, DUT and checker
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FAIL  = 2'd2
    } checker_state_e;

    localparam int unsigned COUNTER_WIDTH = 8;

endpackage

// File: rtl/counter_model.sv
// counter_model: cycle-accurate reference of the counter DUT.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   enb         : enable; expected count advances by one on enabled edges
//   load        : resynchronise; exp takes load_val instead of advancing
//   load_val    : value loaded on resync
//   exp         : expected count
//   exp_carry   : expected combinational carry (enb && exp at all-ones)
module counter_model
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enb,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] exp,
    output logic             exp_carry
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp <= '0;
        end else if (load) begin
            exp <= load_val;
        end else begin
            exp <= exp + WIDTH'(enb);
        end
    end

    assign exp_carry = enb && (exp == '1);

endmodule

// File: rtl/counter_checker.sv
// counter_checker: observational monitor for the counter DUT. Tracks a
// reference model, compares count/carryout every clock while in CHECK and
// reports mismatches, a saturating error count, checked wraps and a verdict.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   enb        : DUT enable (tapped)
//   count      : DUT count output
//   carryout   : DUT carry output
//   mismatch   : registered one-cycle pulse for a mismatch at the previous edge
//   err_cnt    : saturating mismatch count
//   wrap_cnt   : number of correctly checked wraps (modulo 2^WRAP_W)
//   state      : checker state
//   pass       : high while in CHECK with err_cnt == 0
// Build option: define COUNTER_CHECKER_FATAL_EN to get $error on every
// mismatch and $fatal on entry to FAIL; otherwise the block is signal-only.
module counter_checker
    import counter_pkg::*;
#(
    parameter int unsigned WIDTH  = COUNTER_WIDTH,
    parameter int unsigned ERR_W  = 4,
    parameter int unsigned WRAP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enb,
    input  logic [WIDTH-1:0]  count,
    input  logic              carryout,
    output logic              mismatch,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt,
    output checker_state_e    state,
    output logic              pass
);

    // One below saturation: a mismatch here saturates and ends checking.
    localparam logic [ERR_W-1:0] ERR_LAST = {{(ERR_W-1){1'b1}}, 1'b0};

    checker_state_e   state_next;
    logic [WIDTH-1:0] exp;
    logic             exp_carry;
    logic [WIDTH-1:0] load_val;
    logic             checking;
    logic             count_ok;
    logic             carry_ok;
    logic             mis_now;
    logic             wrap_now;

    // On a mismatch the model jumps to where the DUT will be next, so a
    // single slip is reported once instead of on every following cycle.
    counter_model #(
        .WIDTH (WIDTH)
    ) u_model (
        .clk       (clk),
        .rst_n     (rst_n),
        .enb       (enb),
        .load      (mis_now),
        .load_val  (load_val),
        .exp       (exp),
        .exp_carry (exp_carry)
    );

    always_comb begin
        checking = (state == CHECK);
        count_ok = (count == exp);
        carry_ok = (carryout == exp_carry);
        mis_now  = checking && !(count_ok && carry_ok);
        wrap_now = checking && enb && (exp == '1) && count_ok && carry_ok;
        load_val = count + WIDTH'(enb);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = CHECK;
            CHECK:   if (mis_now && (err_cnt == ERR_LAST)) state_next = FAIL;
            FAIL:    state_next = FAIL;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            mismatch <= 1'b0;
            err_cnt  <= '0;
            wrap_cnt <= '0;
        end else begin
            state    <= state_next;
            mismatch <= mis_now;
            if (mis_now && (err_cnt != '1)) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
            if (wrap_now) begin
                wrap_cnt <= wrap_cnt + WRAP_W'(1);
            end
        end
    end

    assign pass = (state == CHECK) && (err_cnt == '0);

`ifdef COUNTER_CHECKER_FATAL_EN
    logic [31:0] cycle_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mis_now) begin
            $error("counter_checker: mismatch at cycle %0d exp=%0d count=%0d carryout=%0b",
                   cycle_cnt, exp, count, carryout);
        end
        if (rst_n && (state == CHECK) && (state_next == FAIL)) begin
            $fatal(1, "counter_checker: error count saturated at cycle %0d", cycle_cnt);
        end
    end
`else
    // Signal-only build: the enclosing top judges the run from pass/err_cnt.
`endif

endmodule
